// File: rtl/multi_digit_counter.sv
// Cascaded modulo-RADIX up/down counter of DIGITS 4-bit digits with load and ripple carry out.
// Defining MULTI_DIGIT_COUNTER_SYNC_CLR_EN adds the synchronous active-low clear input sclr_n.
module multi_digit_counter #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RADIX  = 10
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  ld_n,
  input  logic                  ent,
  input  logic                  enp,
  input  logic                  u_d,
`ifdef MULTI_DIGIT_COUNTER_SYNC_CLR_EN
  input  logic                  sclr_n,
`endif
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  rco
);

  localparam int unsigned W         = 4 * DIGITS;
  localparam logic [3:0]  MAX_DIGIT = 4'(RADIX - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] cnt_val;
  logic         all_term;

  // Ripple the carry/borrow through the digits; a digit only steps when every lower digit terminates.
  always_comb begin
    logic run;
    logic term;
    logic [3:0] dig;
    run     = 1'b1;
    term    = 1'b0;
    dig     = 4'd0;
    cnt_val = q_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig  = q_q[4*k +: 4];
      term = u_d ? (dig >= MAX_DIGIT) : (dig == 4'd0);
      if (run) begin
        if (term) begin
          cnt_val[4*k +: 4] = u_d ? 4'd0 : MAX_DIGIT;
        end else begin
          cnt_val[4*k +: 4] = u_d ? (dig + 4'd1) : (dig - 4'd1);
        end
      end
      run = run & term;
    end
    all_term = run;
  end

  // Next state: (sync clear), load, count, hold.
  always_comb begin
    q_d = q_q;
    if (!ld_n) begin
      q_d = d;
    end else if (ent && enp) begin
      q_d = cnt_val;
    end
`ifdef MULTI_DIGIT_COUNTER_SYNC_CLR_EN
    if (!sclr_n) begin
      q_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign rco = ent & all_term;

endmodule
